pipe_scheduler: RTL and testbench
=================================

# pipe_scheduler

Sequences the pipe field for Flappy. It owns NUM_PIPES pipe slots and scrolls them left on each frame tick. Pipes that leave the screen are respawned at the right with a pseudo-random gap height. The block presents the single "current" pipe (nearest pipe not yet passed) to the collision checker as X_Edge/Y_Edge, and counts the score each time the bird clears a pipe. It sits between the game top level (Start/Ack, frame tick), the collision checker (consumes X_Edge/Y_Edge, returns Lose) and the VGA renderer (consumes all slot positions).

## Interface
- NUM_PIPES, 4: number of pipe slots (power of two).
- PIPE_W, 80: pipe width in pixels (must match the collision checker).
- GAP_H, 100: gap height in pixels (must match the collision checker).
- SPACING, 160: horizontal distance between consecutive pipe left edges.
- INIT_X, 320: slot 0 left edge after reset/reload.
- INIT_Y, 140: gap top edge of every slot after reset/reload.
- GAP_MIN, 60: minimum gap top edge on respawn.
- SPEED, 2: pixels moved per Frame_Tick.
- SEED, 16'hACE1: LFSR reset value (nonzero).
- Clk input 1: system clock.
- reset input 1: asynchronous, active-high.
- Start input 1: level; begins a game from IDLE.
- Ack input 1: level; leaves OVER.
- Lose input 1: collision flag from the checker.
- Frame_Tick input 1: one-cycle pulse per video frame.
- Bird_X input 10: bird x position, unsigned; must be held in [PIPE_W+SPEED+1, INIT_X-1].
- X_Edge output 10: left edge of the current pipe.
- Y_Edge output 10: gap top edge of the current pipe.
- Pipe_X_All output 10*NUM_PIPES: all slot left edges; slot i occupies bits [10i+9:10i].
- Pipe_Y_All output 10*NUM_PIPES: all slot gap tops, same packing.
- Score output 8: pipes passed, saturating at 255.
- Q_Idle, Q_Run, Q_Over output 1 each: one-hot state.

## Operation
- States and transitions:
  - IDLE → RUN on Start. On this transition, Score is cleared to 0 and the current-pipe pointer cur is set to 0.
  - RUN → OVER on Lose.
  - OVER → IDLE on Ack. On this transition, all slots are reloaded to their init values.
- Ignored inputs: Start outside IDLE, Lose outside RUN, Ack outside OVER.
- Slot init values: X[i] = INIT_X + i*SPACING; Y[i] = INIT_Y. With defaults: 320, 480, 640, 800.
- Scrolling, on Frame_Tick in RUN, per slot:
  - If X[i] < SPEED: X[i] ← X[i] + NUM_PIPES*SPACING − SPEED, and Y[i] ← GAP_MIN + lfsr[7:0] (respawn).
  - Otherwise: X[i] ← X[i] − SPEED.
  - This preserves exact spacing. At most one slot respawns per tick.
- Pass detection in RUN, every cycle:
  - Condition: X[cur] + PIPE_W < Bird_X, computed at 11 bits.
  - Action: Score increments (holds at 255) and cur ← (cur+1) mod NUM_PIPES.
  - At most one pass is detected per cycle.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Steps every Clk in every state, so gap heights depend on player timing.
  - Respawn samples the current value before that cycle's step.
- Output muxing: X_Edge/Y_Edge are a combinational mux of slot cur. Pipe_X_All/Pipe_Y_All are direct register outputs.
- Range rule: all X values stay within [0, max(INIT_X+(NUM_PIPES−1)*SPACING, NUM_PIPES*SPACING)] < 1024. Parameter sets violating this are unsupported.

## Timing
- Reset values (asynchronous):
  - State IDLE: Q_Idle=1, Q_Run=0, Q_Over=0.
  - Slots at init values.
  - cur=0, Score=0, lfsr=SEED.
  - X_Edge=INIT_X, Y_Edge=INIT_Y.
- Frame_Tick sampled at edge n: new X/Y are visible after edge n. A resulting pass updates Score/cur after edge n+1.
- Lose and Frame_Tick in the same cycle: the state goes to OVER and no scroll occurs.
- OVER holds all positions and Score frozen.
- Start and Ack asserted simultaneously in OVER: only Ack acts. Start is honoured from IDLE on a later cycle.
- Reset mid-RUN or mid-OVER: all registers return to reset values immediately, with no partial scroll.

## Structure
- Shared package flappy_pkg holds:
  - SCREEN_W=640 and SCREEN_H=480.
  - PIPE_W and GAP_H, shared with the collision checker.
  - State encodings IDLE/RUN/OVER.
- Natural sub-module pipe_lfsr: 16-bit Galois LFSR with SEED parameter and 16-bit output. The rest is one module.

## Test plan
- Reset → Pipe_X_All slots = 320, 480, 640, 800; all Y = 140; Score=0; Q_Idle=1; X_Edge=320.
- Start, then 10 Frame_Ticks → slot 0 X=300 and slot 3 X=780; Q_Run=1.
- Run until slot 0 X=0 → next tick slot 0 X=638, Y = 60 + lfsr[7:0] (within 60..315), and slot 0 sits exactly 160 right of slot 3.
- Bird_X=200 → when slot 0 X reaches 118, Score becomes 1 two edges after the tick, and X_Edge switches to slot 1's value.
- Lose and Frame_Tick in the same cycle → Q_Over, positions unchanged. Then Ack → Q_Idle with slots reloaded; Score kept until the next Start, which clears it to 0.
- Async reset pulse mid-RUN → reset values immediately. Separately, force 255 passes → Score holds at 255.

Source files
------------

// File: rtl/flappy_pkg.sv
// flappy_pkg
// Shared constants and types for the Flappy game blocks.
// Screen geometry, pipe geometry (shared by pipe_scheduler and the
// collision checker) and the game state encoding live here so that every
// block agrees on them.
package flappy_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Pipe geometry; the collision checker must use the same values.
  localparam int PIPE_W = 80;
  localparam int GAP_H  = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_lfsr.sv
// pipe_lfsr
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// It steps on every clock regardless of game state, so the sequence seen
// by the pipe respawn logic depends on how long the player takes to act.
//
// Ports:
//   Clk    - system clock
//   reset  - asynchronous, active-high; loads SEED
//   lfsr_o - current register value (value before this cycle's step)
module pipe_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        reset,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Right-shifting Galois form: when the bit shifted out is 1, the tap
  // mask for exponents 16/14/13/11 (bits 15/13/12/10) is folded back in.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/pipe_scheduler.sv
// pipe_scheduler
// Owns the pipe slots for Flappy: scrolls them left on each frame tick while
// a game runs, respawns pipes that leave the screen at the right with a
// pseudo-random gap height, tracks the nearest not-yet-passed pipe for the
// collision checker and counts the score.
//
// Ports:
//   Clk, reset          - system clock; asynchronous active-high reset
//   Start, Ack          - game control levels (IDLE->RUN, OVER->IDLE)
//   Lose                - collision flag from the collision checker
//   Frame_Tick          - one-cycle pulse per video frame
//   Bird_X              - bird x position
//   X_Edge, Y_Edge      - left edge / gap top of the current pipe
//   Pipe_X_All/Y_All    - every slot, slot i in bits [10i+9:10i]
//   Score               - pipes passed, saturating at 255
//   Q_Idle/Q_Run/Q_Over - one-hot state
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int          NUM_PIPES = 4,
  parameter int          PIPE_W    = flappy_pkg::PIPE_W,
  parameter int          GAP_H     = flappy_pkg::GAP_H,
  parameter int          SPACING   = 160,
  parameter int          INIT_X    = 320,
  parameter int          INIT_Y    = 140,
  parameter int          GAP_MIN   = 60,
  parameter int          SPEED     = 2,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic                   Ack,
  input  logic                   Lose,
  input  logic                   Frame_Tick,
  input  logic [9:0]             Bird_X,
  output logic [9:0]             X_Edge,
  output logic [9:0]             Y_Edge,
  output logic [10*NUM_PIPES-1:0] Pipe_X_All,
  output logic [10*NUM_PIPES-1:0] Pipe_Y_All,
  output logic [7:0]             Score,
  output logic                   Q_Idle,
  output logic                   Q_Run,
  output logic                   Q_Over
);

  localparam int CurW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  // Adding a full period minus one step keeps the respawned pipe exactly
  // SPACING to the right of the last pipe in the chain.
  localparam logic [10:0] WrapAdd = 11'(NUM_PIPES * SPACING - SPEED);

  state_e          state_q, state_d;
  logic [9:0]      x_q [NUM_PIPES];
  logic [9:0]      x_d [NUM_PIPES];
  logic [9:0]      y_q [NUM_PIPES];
  logic [9:0]      y_d [NUM_PIPES];
  logic [CurW-1:0] cur_q, cur_d;
  logic [7:0]      score_q, score_d;
  logic [15:0]     lfsr;
  logic            passHit;
  logic            unusedLfsrHigh;

  pipe_lfsr #(
    .SEED(SEED)
  ) uLfsr (
    .Clk   (Clk),
    .reset (reset),
    .lfsr_o(lfsr)
  );

  // Only the low byte feeds gap heights; the upper bits just keep the
  // sequence long.
  assign unusedLfsrHigh = ^lfsr[15:8];

  // Game state transitions; inputs not meaningful in a state are ignored,
  // which also gives Ack priority over Start while in OVER.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (Lose)  state_d = OVER;
      OVER:    if (Ack)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pass test widened to 11 bits so X + PIPE_W cannot wrap.
  assign passHit = (state_q == RUN) &&
                   (({1'b0, x_q[cur_q]} + 11'(PIPE_W)) < {1'b0, Bird_X});

  // Slot update: reload when leaving OVER, scroll on a frame tick in RUN.
  // A tick that coincides with Lose is dropped so the field freezes at the
  // position where the collision was seen.
  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (state_q == OVER && Ack) begin
        x_d[i] = 10'(INIT_X + i * SPACING);
        y_d[i] = 10'(INIT_Y);
      end else if (state_q == RUN && Frame_Tick && !Lose) begin
        if (x_q[i] < 10'(SPEED)) begin
          x_d[i] = 10'({1'b0, x_q[i]} + WrapAdd);
          y_d[i] = 10'(GAP_MIN) + {2'b00, lfsr[7:0]};
        end else begin
          x_d[i] = x_q[i] - 10'(SPEED);
        end
      end
    end
  end

  // Score and current-pipe pointer; the pointer wraps naturally because
  // NUM_PIPES is a power of two.
  always_comb begin
    score_d = score_q;
    cur_d   = cur_q;
    if (state_q == IDLE && Start) begin
      score_d = 8'd0;
      cur_d   = '0;
    end else if (passHit) begin
      if (score_q != 8'hFF) begin
        score_d = score_q + 8'd1;
      end
      cur_d = cur_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      score_q <= 8'd0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= 10'(INIT_X + i * SPACING);
        y_q[i] <= 10'(INIT_Y);
      end
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      score_q <= score_d;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  assign X_Edge = x_q[cur_q];
  assign Y_Edge = y_q[cur_q];
  assign Score  = score_q;
  assign Q_Idle = (state_q == IDLE);
  assign Q_Run  = (state_q == RUN);
  assign Q_Over = (state_q == OVER);

  for (genvar g = 0; g < NUM_PIPES; g++) begin : gPack
    assign Pipe_X_All[10*g +: 10] = x_q[g];
    assign Pipe_Y_All[10*g +: 10] = y_q[g];
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler
// Directed bench for pipe_scheduler: expected values are queued as each
// stimulus step is driven and popped in order when the outputs are sampled
// on the falling edge.
module tb_pipe_scheduler;

  logic        Clk = 1'b0;
  logic        reset;
  logic        Start, Ack, Lose, Frame_Tick;
  logic [9:0]  Bird_X;
  logic [9:0]  X_Edge, Y_Edge;
  logic [39:0] Pipe_X_All, Pipe_Y_All;
  logic [7:0]  Score;
  logic        Q_Idle, Q_Run, Q_Over;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;
  exp_t sbQ[$];

  logic [15:0] modelLfsr;
  logic [15:0] snap;
  logic [31:0] expY;

  pipe_scheduler dut (
    .Clk       (Clk),
    .reset     (reset),
    .Start     (Start),
    .Ack       (Ack),
    .Lose      (Lose),
    .Frame_Tick(Frame_Tick),
    .Bird_X    (Bird_X),
    .X_Edge    (X_Edge),
    .Y_Edge    (Y_Edge),
    .Pipe_X_All(Pipe_X_All),
    .Pipe_Y_All(Pipe_Y_All),
    .Score     (Score),
    .Q_Idle    (Q_Idle),
    .Q_Run     (Q_Run),
    .Q_Over    (Q_Over)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: shift right, fold in taps 16/14/13/11 on a carried-out 1.
  always @(posedge Clk or posedge reset) begin
    if (reset) modelLfsr <= 16'hACE1;
    else       modelLfsr <= modelLfsr[0] ? ((modelLfsr >> 1) ^ 16'hB400) : (modelLfsr >> 1);
  end

  // Safety net so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] slotX(input int i);
    return {22'd0, Pipe_X_All[10*i +: 10]};
  endfunction

  function automatic logic [31:0] slotY(input int i);
    return {22'd0, Pipe_Y_All[10*i +: 10]};
  endfunction

  task automatic expectVal(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    compared++;
    if (sbQ.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=<none>", observed);
      return;
    end
    e = sbQ.pop_front();
    assert (observed === e.value) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, observed, e.value);
    end
  endtask

  // Drive one clock cycle of inputs starting at a falling edge, then return
  // to idle inputs at the next falling edge.
  task automatic applyStimulus(input logic tick, input logic lose,
                               input logic start, input logic ack);
    Frame_Tick = tick;
    Lose       = lose;
    Start      = start;
    Ack        = ack;
    @(posedge Clk);
    @(negedge Clk);
    Frame_Tick = 1'b0;
    Lose       = 1'b0;
    Start      = 1'b0;
    Ack        = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Ack = 1'b0; Lose = 1'b0; Frame_Tick = 1'b0;
    Bird_X = 10'd200;
    @(negedge Clk);
    @(negedge Clk);

    // Reset state
    for (int i = 0; i < 4; i++) expectVal($sformatf("reset_x%0d", i), 32'(320 + 160 * i));
    for (int i = 0; i < 4; i++) expectVal($sformatf("reset_y%0d", i), 32'd140);
    expectVal("reset_score", 0); expectVal("reset_idle", 1);
    expectVal("reset_run", 0);   expectVal("reset_over", 0);
    expectVal("reset_xedge", 320); expectVal("reset_yedge", 140);
    for (int i = 0; i < 4; i++) checkOutput(slotX(i));
    for (int i = 0; i < 4; i++) checkOutput(slotY(i));
    checkOutput(32'(Score)); checkOutput(32'(Q_Idle));
    checkOutput(32'(Q_Run)); checkOutput(32'(Q_Over));
    checkOutput(32'(X_Edge)); checkOutput(32'(Y_Edge));
    reset = 1'b0;

    // Start the game
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    expectVal("start_run", 1); expectVal("start_idle", 0); expectVal("start_score", 0);
    checkOutput(32'(Q_Run)); checkOutput(32'(Q_Idle)); checkOutput(32'(Score));

    // Ten frames of scrolling
    ticks(10);
    expectVal("t10_x0", 300); expectVal("t10_x3", 780); expectVal("t10_run", 1);
    checkOutput(slotX(0)); checkOutput(slotX(3)); checkOutput(32'(Q_Run));

    // Approach the first pass with Bird_X=200 (pass once X < 120)
    ticks(90);
    expectVal("t100_x0", 120); expectVal("t100_score", 0); expectVal("t100_xedge", 120);
    checkOutput(slotX(0)); checkOutput(32'(Score)); checkOutput(32'(X_Edge));
    ticks(1);
    expectVal("t101_x0", 118); expectVal("t101_score", 0); expectVal("t101_xedge", 118);
    checkOutput(slotX(0)); checkOutput(32'(Score)); checkOutput(32'(X_Edge));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    expectVal("pass_score", 1); expectVal("pass_xedge", 278); expectVal("pass_yedge", 140);
    checkOutput(32'(Score)); checkOutput(32'(X_Edge)); checkOutput(32'(Y_Edge));

    // Run slot 0 down to zero, then respawn it
    ticks(59);
    expectVal("t160_x0", 0);
    checkOutput(slotX(0));
    snap = modelLfsr;
    expY = 32'd60 + 32'(snap[7:0]);
    ticks(1);
    expectVal("respawn_x0", 638); expectVal("respawn_y0", expY);
    expectVal("respawn_x3", 478); expectVal("respawn_spacing", 160);
    expectVal("respawn_y_range", 1);
    checkOutput(slotX(0)); checkOutput(slotY(0)); checkOutput(slotX(3));
    checkOutput(slotX(0) - slotX(3));
    checkOutput(32'((slotY(0) >= 60) && (slotY(0) <= 315)));

    // Lose with a simultaneous tick: no scroll
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    expectVal("lose_over", 1); expectVal("lose_x0", 638);
    expectVal("lose_x3", 478); expectVal("lose_score", 1);
    checkOutput(32'(Q_Over)); checkOutput(slotX(0)); checkOutput(slotX(3)); checkOutput(32'(Score));

    // Frozen in OVER
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectVal("over_x0", 638); expectVal("over_score", 1); expectVal("over_state", 1);
    checkOutput(slotX(0)); checkOutput(32'(Score)); checkOutput(32'(Q_Over));

    // Ack and Start together: only Ack acts
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    expectVal("ack_idle", 1); expectVal("ack_run", 0); expectVal("ack_x0", 320);
    expectVal("ack_x3", 800); expectVal("ack_y0", 140); expectVal("ack_score", 1);
    checkOutput(32'(Q_Idle)); checkOutput(32'(Q_Run)); checkOutput(slotX(0));
    checkOutput(slotX(3)); checkOutput(slotY(0)); checkOutput(32'(Score));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    expectVal("restart_run", 1); expectVal("restart_score", 0); expectVal("restart_xedge", 320);
    checkOutput(32'(Q_Run)); checkOutput(32'(Score)); checkOutput(32'(X_Edge));

    // Asynchronous reset in the middle of RUN
    ticks(5);
    expectVal("pre_reset_x0", 310);
    checkOutput(slotX(0));
    #2 reset = 1'b1;
    #1;
    expectVal("areset_idle", 1); expectVal("areset_run", 0);
    expectVal("areset_x0", 320); expectVal("areset_score", 0); expectVal("areset_xedge", 320);
    checkOutput(32'(Q_Idle)); checkOutput(32'(Q_Run));
    checkOutput(slotX(0)); checkOutput(32'(Score)); checkOutput(32'(X_Edge));
    @(negedge Clk);
    reset = 1'b0;

    // Score saturation: Bird_X=319 passes pipe k after tick 41+80k
    Bird_X = 10'd319;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(20281);
    expectVal("sat_253", 253);
    checkOutput(32'(Score));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    expectVal("sat_254", 254);
    checkOutput(32'(Score));
    ticks(80);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    expectVal("sat_255", 255);
    checkOutput(32'(Score));
    ticks(640);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    expectVal("sat_hold", 255); expectVal("sat_run", 1);
    checkOutput(32'(Score)); checkOutput(32'(Q_Run));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
